// File: rtl/or1200_dtlb_reload.sv
// DTLB refill controller for the data MMU.
// On a DTLB miss it reads the PTE for the faulting page from the page table.
// If the PTE is present, it writes the DTLB match and translate registers
// through the DMMU SPR port. That port is shared with CPU SPR traffic.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   miss_req/vadr     miss request (level) and faulting virtual address
//   ptbr              page-table base (word aligned)
//   miss_done/err     one-cycle completion pulse, with error qualifier
//   mem_*             PTE read port (req held until ack/err)
//   cpu_spr_*         CPU SPR request in, grant out
//   spr_*             arbitrated DMMU SPR port
//
// The VPN is taken from vadr[31:13], so aw must be at least 32.
// SET_W must not exceed 19.
module or1200_dtlb_reload #(
  parameter int unsigned aw      = 32,
  parameter int unsigned SET_W   = 6,
  parameter logic [15:0] MR_BASE = 16'h0A00,
  parameter logic [15:0] TR_BASE = 16'h0A80
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          miss_req,
  input  logic [aw-1:0] miss_vadr,
  input  logic [aw-1:0] ptbr,
  output logic          miss_done,
  output logic          miss_err,
  output logic          mem_req,
  output logic [aw-1:0] mem_adr,
  input  logic          mem_ack,
  input  logic          mem_err,
  input  logic [31:0]   mem_dat,
  input  logic          cpu_spr_cs,
  input  logic          cpu_spr_write,
  input  logic [31:0]   cpu_spr_addr,
  input  logic [31:0]   cpu_spr_dat,
  output logic          cpu_spr_gnt,
  output logic          spr_cs,
  output logic          spr_write,
  output logic [31:0]   spr_addr,
  output logic [31:0]   spr_dat_o
);

  localparam int unsigned VPN_W = 19;

  typedef enum logic [2:0] {IDLE, FETCH, WR_MR, WR_TR, DONE} state_t;

  state_t           state;
  logic [VPN_W-1:0] vpn_q;
  logic [30:0]      pte_q;
  logic             err_q;
  logic             denied_q;

  logic             eng_req;
  logic             eng_gnt;
  logic             cpu_win;
  logic [31:0]      eng_addr;
  logic [31:0]      eng_dat;
  logic [SET_W-1:0] set_idx;

  // Page-offset bits of the faulting address play no part in the refill.
  logic unused_vadr_lo;
  assign unused_vadr_lo = ^miss_vadr[12:0];

  assign set_idx = vpn_q[SET_W-1:0];

  // SPR arbitration.
  // The CPU normally wins. An engine write that was refused once wins the next cycle.
  // The engine request is masked during reset, so reset shows plain CPU passthrough.
  always_comb begin
    eng_req     = 1'b0;
    eng_gnt     = 1'b0;
    cpu_win     = 1'b0;
    eng_addr    = 32'(MR_BASE) + 32'(set_idx);
    eng_dat     = {vpn_q, 12'h000, 1'b1};
    cpu_spr_gnt = 1'b0;
    spr_cs      = 1'b0;
    spr_write   = 1'b0;
    spr_addr    = 32'h0;
    spr_dat_o   = 32'h0;

    eng_req = rst && ((state == WR_MR) || (state == WR_TR));
    eng_gnt = eng_req && (!cpu_spr_cs || denied_q);
    cpu_win = cpu_spr_cs && !eng_gnt;

    if (state == WR_TR) begin
      eng_addr = 32'(TR_BASE) + 32'(set_idx);
      eng_dat  = {pte_q, 1'b0};
    end

    if (eng_gnt) begin
      spr_cs    = 1'b1;
      spr_write = 1'b1;
      spr_addr  = eng_addr;
      spr_dat_o = eng_dat;
    end else if (cpu_win) begin
      cpu_spr_gnt = 1'b1;
      spr_cs      = cpu_spr_cs;
      spr_write   = cpu_spr_write;
      spr_addr    = cpu_spr_addr;
      spr_dat_o   = cpu_spr_dat;
    end
  end

  // Refill sequencer with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      vpn_q     <= '0;
      pte_q     <= '0;
      err_q     <= 1'b0;
      denied_q  <= 1'b0;
      mem_req   <= 1'b0;
      mem_adr   <= '0;
      miss_done <= 1'b0;
      miss_err  <= 1'b0;
    end else begin
      miss_done <= 1'b0;
      miss_err  <= 1'b0;

      if (eng_gnt)
        denied_q <= 1'b0;
      else if (eng_req)
        denied_q <= 1'b1;

      case (state)
        IDLE: begin
          if (miss_req) begin
            vpn_q   <= miss_vadr[31:13];
            // PTE address wraps modulo 2**aw.
            mem_adr <= ptbr + aw'({miss_vadr[31:13], 2'b00});
            mem_req <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          // A bus error takes priority over a simultaneous ack.
          if (mem_err || (mem_ack && !mem_dat[0])) begin
            mem_req   <= 1'b0;
            err_q     <= 1'b1;
            miss_done <= 1'b1;
            miss_err  <= 1'b1;
            state     <= DONE;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            pte_q   <= mem_dat[31:1];
            state   <= WR_MR;
          end
        end
        WR_MR: begin
          if (eng_gnt)
            state <= WR_TR;
        end
        WR_TR: begin
          if (eng_gnt) begin
            miss_done <= 1'b1;
            miss_err  <= err_q;
            state     <= DONE;
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or1200_dtlb_reload.sv
// Directed testbench for or1200_dtlb_reload.
// Inputs are driven 1 ns after each rising edge, and outputs are checked at that same point.
module tb_or1200_dtlb_reload;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [31:0] miss_vadr;
  logic [31:0] ptbr;
  logic        miss_done;
  logic        miss_err;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_dat;
  logic        cpu_spr_cs;
  logic        cpu_spr_write;
  logic [31:0] cpu_spr_addr;
  logic [31:0] cpu_spr_dat;
  logic        cpu_spr_gnt;
  logic        spr_cs;
  logic        spr_write;
  logic [31:0] spr_addr;
  logic [31:0] spr_dat_o;

  int n_checks = 0;
  int n_fail   = 0;

  or1200_dtlb_reload dut (
    .clk           (clk),
    .rst           (rst),
    .miss_req      (miss_req),
    .miss_vadr     (miss_vadr),
    .ptbr          (ptbr),
    .miss_done     (miss_done),
    .miss_err      (miss_err),
    .mem_req       (mem_req),
    .mem_adr       (mem_adr),
    .mem_ack       (mem_ack),
    .mem_err       (mem_err),
    .mem_dat       (mem_dat),
    .cpu_spr_cs    (cpu_spr_cs),
    .cpu_spr_write (cpu_spr_write),
    .cpu_spr_addr  (cpu_spr_addr),
    .cpu_spr_dat   (cpu_spr_dat),
    .cpu_spr_gnt   (cpu_spr_gnt),
    .spr_cs        (spr_cs),
    .spr_write     (spr_write),
    .spr_addr      (spr_addr),
    .spr_dat_o     (spr_dat_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a miss and check the PTE address that appears in the following cycle.
  task automatic do_miss(input logic [31:0] va, input logic [31:0] pt, input logic [31:0] exp_adr);
    miss_vadr = va;
    ptbr      = pt;
    miss_req  = 1'b1;
    tick();
    check("mem_req_rise", 32'(mem_req), 32'd1);
    check("mem_adr", mem_adr, exp_adr);
  endtask

  // Complete an uncontended refill.
  // The ack comes one cycle after mem_req rises; then check the MR write, the TR write and the done pulse.
  task automatic refill(input logic [31:0] va, input logic [31:0] pt, input logic [31:0] exp_adr,
                        input logic [31:0] pte,
                        input logic [31:0] mr_a, input logic [31:0] mr_d,
                        input logic [31:0] tr_a, input logic [31:0] tr_d);
    do_miss(va, pt, exp_adr);
    tick();
    check("mem_req_held", 32'(mem_req), 32'd1);
    check("mem_adr_stable", mem_adr, exp_adr);
    check("spr_quiet_fetch", 32'(spr_cs), 32'd0);
    mem_ack = 1'b1;
    mem_dat = pte;
    tick();
    mem_ack = 1'b0;
    mem_dat = 32'h0;
    check("mem_req_drop", 32'(mem_req), 32'd0);
    check("mr_cs", 32'(spr_cs), 32'd1);
    check("mr_we", 32'(spr_write), 32'd1);
    check("mr_addr", spr_addr, mr_a);
    check("mr_dat", spr_dat_o, mr_d);
    check("mr_cpu_gnt", 32'(cpu_spr_gnt), 32'd0);
    check("mr_no_done", 32'(miss_done), 32'd0);
    tick();
    check("tr_cs", 32'(spr_cs), 32'd1);
    check("tr_addr", spr_addr, tr_a);
    check("tr_dat", spr_dat_o, tr_d);
    tick();
    check("ok_done", 32'(miss_done), 32'd1);
    check("ok_err", 32'(miss_err), 32'd0);
    check("ok_spr_quiet", 32'(spr_cs), 32'd0);
    miss_req = 1'b0;
    tick();
    check("done_pulse_end", 32'(miss_done), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    miss_req = 1'b0;
    miss_vadr = 32'h0;
    ptbr = 32'h0;
    mem_ack = 1'b0;
    mem_err = 1'b0;
    mem_dat = 32'h0;
    cpu_spr_cs = 1'b0;
    cpu_spr_write = 1'b0;
    cpu_spr_addr = 32'h0;
    cpu_spr_dat = 32'h0;

    // Reset state.
    tick();
    tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_adr", mem_adr, 32'h0);
    check("rst_done", 32'(miss_done), 32'd0);
    check("rst_err", 32'(miss_err), 32'd0);
    check("rst_spr_cs", 32'(spr_cs), 32'd0);
    check("rst_spr_addr", spr_addr, 32'h0);
    rst = 1'b1;
    tick();

    // Basic refill: set 3, VPN 3.
    refill(32'h0000_6004, 32'h0010_0000, 32'h0010_000C, 32'h1234_5001,
           32'h0000_0A03, 32'h0000_6001, 32'h0000_0A83, 32'h1234_5000);

    // Not-present PTE: the ack arrives in the first FETCH cycle.
    do_miss(32'h0000_6004, 32'h0010_0000, 32'h0010_000C);
    mem_ack = 1'b1;
    mem_dat = 32'h1234_5000;
    tick();
    mem_ack = 1'b0;
    check("np_done", 32'(miss_done), 32'd1);
    check("np_err", 32'(miss_err), 32'd1);
    check("np_spr_cs", 32'(spr_cs), 32'd0);
    check("np_mem_req", 32'(mem_req), 32'd0);
    miss_req = 1'b0;
    tick();
    check("np_done_end", 32'(miss_done), 32'd0);
    check("np_spr_cs_after", 32'(spr_cs), 32'd0);

    // Bus error together with an ack that carries a present PTE.
    do_miss(32'h0000_6004, 32'h0010_0000, 32'h0010_000C);
    mem_ack = 1'b1;
    mem_err = 1'b1;
    mem_dat = 32'h1234_5001;
    tick();
    mem_ack = 1'b0;
    mem_err = 1'b0;
    check("be_done", 32'(miss_done), 32'd1);
    check("be_err", 32'(miss_err), 32'd1);
    check("be_mem_req", 32'(mem_req), 32'd0);
    check("be_spr_cs", 32'(spr_cs), 32'd0);
    miss_req = 1'b0;
    tick();
    check("be_spr_cs_after", 32'(spr_cs), 32'd0);
    check("be_done_end", 32'(miss_done), 32'd0);

    // Contention: the CPU holds its SPR request for the whole refill.
    do_miss(32'h0000_6004, 32'h0010_0000, 32'h0010_000C);
    cpu_spr_cs = 1'b1;
    cpu_spr_write = 1'b1;
    cpu_spr_addr = 32'd10;
    cpu_spr_dat = 32'hACAC_01F1;
    #1;
    check("ct_fetch_gnt", 32'(cpu_spr_gnt), 32'd1);
    mem_ack = 1'b1;
    mem_dat = 32'h1234_5001;
    tick();
    mem_ack = 1'b0;
    check("ct_c1_gnt", 32'(cpu_spr_gnt), 32'd1);
    check("ct_c1_addr", spr_addr, 32'd10);
    check("ct_c1_dat", spr_dat_o, 32'hACAC_01F1);
    tick();
    check("ct_mr_gnt", 32'(cpu_spr_gnt), 32'd0);
    check("ct_mr_addr", spr_addr, 32'h0000_0A03);
    check("ct_mr_dat", spr_dat_o, 32'h0000_6001);
    tick();
    check("ct_c2_gnt", 32'(cpu_spr_gnt), 32'd1);
    check("ct_c2_addr", spr_addr, 32'd10);
    tick();
    check("ct_tr_gnt", 32'(cpu_spr_gnt), 32'd0);
    check("ct_tr_addr", spr_addr, 32'h0000_0A83);
    check("ct_tr_dat", spr_dat_o, 32'h1234_5000);
    check("ct_tr_no_done", 32'(miss_done), 32'd0);
    tick();
    check("ct_done", 32'(miss_done), 32'd1);
    check("ct_err", 32'(miss_err), 32'd0);
    check("ct_idle_gnt", 32'(cpu_spr_gnt), 32'd1);
    miss_req = 1'b0;
    cpu_spr_cs = 1'b0;
    cpu_spr_write = 1'b0;
    tick();
    check("ct_spr_cs_off", 32'(spr_cs), 32'd0);
    check("ct_gnt_off", 32'(cpu_spr_gnt), 32'd0);

    // Reset while a fetch is outstanding; a late ack must be ignored.
    do_miss(32'h0000_6004, 32'h0010_0000, 32'h0010_000C);
    rst = 1'b0;
    miss_req = 1'b0;
    tick();
    rst = 1'b1;
    check("mr_rst_mem_req", 32'(mem_req), 32'd0);
    check("mr_rst_mem_adr", mem_adr, 32'h0);
    check("mr_rst_done", 32'(miss_done), 32'd0);
    mem_ack = 1'b1;
    mem_dat = 32'h1234_5001;
    tick();
    mem_ack = 1'b0;
    check("late_ack_mem_req", 32'(mem_req), 32'd0);
    check("late_ack_spr_cs", 32'(spr_cs), 32'd0);
    check("late_ack_done", 32'(miss_done), 32'd0);
    tick();
    check("late_ack_spr_cs2", 32'(spr_cs), 32'd0);
    check("late_ack_done2", 32'(miss_done), 32'd0);
    refill(32'h0000_6004, 32'h0010_0000, 32'h0010_000C, 32'h1234_5001,
           32'h0000_0A03, 32'h0000_6001, 32'h0000_0A83, 32'h1234_5000);

    // Address wrap: 0xFFFFFFF0 + 0x14 = 0x0000_0004; set 5, VPN 5.
    refill(32'h0000_A000, 32'hFFFF_FFF0, 32'h0000_0004, 32'h00AB_C001,
           32'h0000_0A05, 32'h0000_A001, 32'h0000_0A85, 32'h00AB_C000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
